// File: rtl/elevator_controller.sv
// Single-car elevator controller: call latching, SCAN direction choice, door sequencing.
// Ports: clock, an_reset (async, active-high); buttons/sensor_* from plant; engine/door/floor/pending/busy out.
module elevator_controller #(
    parameter int BUTTONS_WIDTH  = 8,
    parameter int FLOOR_W        = 3,
    parameter int DOOR_OPEN_TIME = 20
) (
    input  logic                     clock,
    input  logic                     an_reset,
    input  logic [BUTTONS_WIDTH-1:0] buttons,
    input  logic [1:0]               sensor_door,
    input  logic                     sensor_up,
    input  logic                     sensor_down,
    output logic [1:0]               engine,
    output logic [1:0]               door,
    output logic [FLOOR_W-1:0]       floor,
    output logic [BUTTONS_WIDTH-1:0] pending,
    output logic                     busy
);

    localparam int TW = $clog2(DOOR_OPEN_TIME + 1);
    localparam logic [TW-1:0] TLOAD = TW'(DOOR_OPEN_TIME - 1);
    localparam logic [BUTTONS_WIDTH-1:0] ONE =
        {{(BUTTONS_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;
    localparam logic [1:0] DR_HOLD  = 2'b00;
    localparam logic [1:0] DR_OPEN  = 2'b01;
    localparam logic [1:0] DR_CLOSE = 2'b10;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_UP,
        S_DOWN,
        S_OPENING,
        S_DWELL,
        S_CLOSING
    } state_t;

    state_t            state;
    logic              dir_up;
    logic [TW-1:0]     timer;
    logic [1:0]        engine_q;
    logic              up_q;
    logic              down_q;

    logic [BUTTONS_WIDTH-1:0] floor_oh;
    logic [BUTTONS_WIDTH-1:0] reqs;
    logic [BUTTONS_WIDTH-1:0] mask_here;
    logic [BUTTONS_WIDTH-1:0] clr;
    logic up_edge, down_edge;
    logic door_closed, door_open;
    logic req_here, req_above, req_below;
    logic stop_up, stop_down;
    logic press_here;
    logic at_top, at_bottom;

    always_comb begin
        floor_oh    = ONE << floor;
        up_edge     = sensor_up & ~up_q;
        down_edge   = sensor_down & ~down_q;
        door_closed = (sensor_door == 2'b10);
        door_open   = (sensor_door == 2'b01);
        req_here    = |(pending & floor_oh);
        // bits strictly above / strictly below the current floor
        req_above   = |(pending & ~((floor_oh << 1) - ONE));
        req_below   = |(pending & (floor_oh - ONE));
        // a press landing on the arrival cycle still stops the car
        reqs        = pending | buttons;
        stop_up     = |(reqs & (floor_oh << 1));
        stop_down   = |(reqs & (floor_oh >> 1));
        press_here  = |(buttons & floor_oh);
        at_top      = (floor == FLOOR_W'(BUTTONS_WIDTH - 1));
        at_bottom   = (floor == '0);
        // presses at the open door reopen/extend instead of latching
        mask_here   = '0;
        if (state == S_DWELL || state == S_CLOSING)
            mask_here = floor_oh;
        clr = '0;
        if (state == S_OPENING && door_open)
            clr = floor_oh;
    end

    // motion only while the door reads fully closed
    assign engine = door_closed ? engine_q : ENG_STOP;

    always_ff @(posedge clock or posedge an_reset) begin
        if (an_reset) begin
            state    <= S_INIT;
            dir_up   <= 1'b1;
            timer    <= '0;
            engine_q <= ENG_STOP;
            door     <= DR_CLOSE;
            busy     <= 1'b1;
            floor    <= '0;
            pending  <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            up_q    <= sensor_up;
            down_q  <= sensor_down;
            pending <= (pending | (buttons & ~mask_here)) & ~clr;
            case (state)
                S_INIT: begin
                    if (door_closed) begin
                        state    <= S_IDLE;
                        engine_q <= ENG_STOP;
                        door     <= DR_HOLD;
                        busy     <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (req_here) begin
                        state <= S_OPENING;
                        door  <= DR_OPEN;
                        busy  <= 1'b1;
                    end else if (req_above && (dir_up || !req_below)) begin
                        dir_up   <= 1'b1;
                        state    <= S_UP;
                        engine_q <= ENG_UP;
                        busy     <= 1'b1;
                    end else if (req_below) begin
                        dir_up   <= 1'b0;
                        state    <= S_DOWN;
                        engine_q <= ENG_DOWN;
                        busy     <= 1'b1;
                    end
                end
                S_UP: begin
                    if (up_edge && !at_top) begin
                        floor <= floor + FLOOR_W'(1);
                        if (stop_up) begin
                            state    <= S_OPENING;
                            engine_q <= ENG_STOP;
                            door     <= DR_OPEN;
                        end else if (floor == FLOOR_W'(BUTTONS_WIDTH - 2)) begin
                            state    <= S_IDLE;
                            engine_q <= ENG_STOP;
                            busy     <= 1'b0;
                        end
                    end
                end
                S_DOWN: begin
                    if (down_edge && !at_bottom) begin
                        floor <= floor - FLOOR_W'(1);
                        if (stop_down) begin
                            state    <= S_OPENING;
                            engine_q <= ENG_STOP;
                            door     <= DR_OPEN;
                        end else if (floor == FLOOR_W'(1)) begin
                            state    <= S_IDLE;
                            engine_q <= ENG_STOP;
                            busy     <= 1'b0;
                        end
                    end
                end
                S_OPENING: begin
                    if (door_open) begin
                        state <= S_DWELL;
                        timer <= TLOAD;
                        door  <= DR_HOLD;
                    end
                end
                S_DWELL: begin
                    if (press_here) begin
                        timer <= TLOAD;
                    end else if (timer == '0) begin
                        state <= S_CLOSING;
                        door  <= DR_CLOSE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_CLOSING: begin
                    if (press_here) begin
                        state <= S_OPENING;
                        door  <= DR_OPEN;
                    end else if (door_closed) begin
                        state <= S_IDLE;
                        door  <= DR_HOLD;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_INIT;
                    engine_q <= ENG_STOP;
                    door     <= DR_CLOSE;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: plant model, SCAN reference model, service scoreboard.
module tb_elevator_controller;

    localparam int BW   = 8;
    localparam int FW   = 3;
    localparam int T    = 20;
    localparam int DMAX = 3;

    logic          clock = 1'b0;
    logic          an_reset = 1'b0;
    logic [BW-1:0] buttons = '0;
    logic [1:0]    sd_plant = 2'b10;
    logic          glitch = 1'b1;
    logic [1:0]    sensor_door;
    logic          sensor_up = 1'b0;
    logic          sensor_down = 1'b0;
    logic [1:0]    engine;
    logic [1:0]    door;
    logic [FW-1:0] floor;
    logic [BW-1:0] pending;
    logic          busy;

    assign sensor_door = glitch ? 2'b00 : sd_plant;

    elevator_controller #(
        .BUTTONS_WIDTH(BW),
        .FLOOR_W(FW),
        .DOOR_OPEN_TIME(T)
    ) dut (
        .clock(clock),
        .an_reset(an_reset),
        .buttons(buttons),
        .sensor_door(sensor_door),
        .sensor_up(sensor_up),
        .sensor_down(sensor_down),
        .engine(engine),
        .door(door),
        .floor(floor),
        .pending(pending),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int fl;
        int dwell;
    } svc_t;
    svc_t sb[$];

    int m_floor = 0;
    bit m_dir = 1'b1;

    int pfloor = 0;
    int door_pos = 0;
    int up_cnt = 0;
    int dn_cnt = 0;
    int travel = 3;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // SCAN reference: serve the current floor, then sweep in the
    // current direction, reversing only when that side is empty.
    task automatic plan(input logic [BW-1:0] mask, input int dwell);
        bit s[BW];
        int f;
        int above;
        int below;
        for (int i = 0; i < BW; i++) s[i] = mask[i];
        f = m_floor;
        if (s[f]) begin
            sb.push_back('{f, dwell});
            s[f] = 1'b0;
        end
        forever begin
            above = -1;
            below = -1;
            for (int i = BW - 1; i > f; i--) if (s[i]) above = i;
            for (int i = 0; i < f; i++) if (s[i]) below = i;
            if (above >= 0 && (m_dir || below < 0)) begin
                m_dir = 1'b1;
                f = above;
            end else if (below >= 0) begin
                m_dir = 1'b0;
                f = below;
            end else begin
                break;
            end
            s[f] = 1'b0;
            sb.push_back('{f, dwell});
        end
        m_floor = f;
    endtask

    task automatic issue(input logic [BW-1:0] mask, input int dwell);
        plan(mask, dwell);
        @(negedge clock);
        buttons = mask;
        @(negedge clock);
        buttons = '0;
    endtask

    task automatic wait_door(input logic [1:0] v, input string nm);
        int n = 0;
        while (door != v && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s: door=%0d after timeout, required %0d", nm, door, v);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (3) @(negedge clock);
        while (!(busy == 1'b0 && sb.size() == 0) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL %s: not idle after timeout, busy=%0d queued=%0d",
                     nm, busy, sb.size());
        end
        chk({nm, "_pending"}, int'(pending), 0);
    endtask

    // plant: door travels one step per cycle, car takes 2..5 cycles per floor
    initial begin
        forever begin
            @(negedge clock);
            if (door == 2'b01 && door_pos < DMAX) door_pos++;
            else if (door == 2'b10 && door_pos > 0) door_pos--;
            sensor_up = 1'b0;
            sensor_down = 1'b0;
            if (engine == 2'b01) begin
                up_cnt++;
                if (up_cnt >= travel) begin
                    sensor_up = 1'b1;
                    pfloor++;
                    up_cnt = 0;
                    travel = int'($urandom_range(2, 5));
                end
            end else if (engine == 2'b10) begin
                dn_cnt++;
                if (dn_cnt >= travel) begin
                    sensor_down = 1'b1;
                    pfloor--;
                    dn_cnt = 0;
                    travel = int'($urandom_range(2, 5));
                end
            end
            if (door_pos == DMAX) sd_plant = 2'b01;
            else if (door_pos == 0) sd_plant = 2'b10;
            else sd_plant = 2'b00;
        end
    end

    // monitor: each completed dwell is one service, popped from the scoreboard
    initial begin
        logic [1:0] pdoor;
        int pf;
        int dcnt;
        bit in_dwell;
        svc_t e;
        pdoor = 2'b10;
        pf = 0;
        dcnt = 0;
        in_dwell = 1'b0;
        forever begin
            @(negedge clock);
            if (an_reset) begin
                in_dwell = 1'b0;
                pdoor = door;
                pf = int'(floor);
                continue;
            end
            if (sensor_door != 2'b10) chk("interlock", int'(engine), 0);
            if (int'(floor) != pf) begin
                chk("floor_step", int'(int'(floor) == pf + 1 || int'(floor) + 1 == pf), 1);
                chk("floor_vs_plant", int'(floor), pfloor);
            end
            if (pdoor == 2'b01 && door == 2'b00) begin
                in_dwell = 1'b1;
                dcnt = 0;
            end
            if (in_dwell && door == 2'b00) dcnt++;
            if (in_dwell && door == 2'b10) begin
                in_dwell = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_service: floor %0d served, none queued", floor);
                end else begin
                    e = sb.pop_front();
                    chk("service_floor", int'(floor), e.fl);
                    chk("dwell_len", dcnt, e.dwell);
                    chk("pending_cleared", int'(pending[floor]), 0);
                end
            end
            pdoor = door;
            pf = int'(floor);
        end
    end

    initial begin
        int n;
        logic [BW-1:0] mask;
        #1 an_reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_engine", int'(engine), 0);
        chk("rst_door", int'(door), 2);
        chk("rst_floor", int'(floor), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_busy", int'(busy), 1);
        an_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("init_door", int'(door), 2);
            chk("init_busy", int'(busy), 1);
        end
        glitch = 1'b0;
        @(negedge clock);
        chk("idle_door", int'(door), 0);
        chk("idle_engine", int'(engine), 0);
        chk("idle_floor", int'(floor), 0);
        chk("idle_busy", int'(busy), 0);

        // floor 0 -> 3
        plan(8'h08, T);
        @(negedge clock);
        buttons = 8'h08;
        @(negedge clock);
        buttons = '0;
        chk("latch_pending", int'(pending), 8);
        @(negedge clock);
        chk("start_engine", int'(engine), 1);
        wait_idle("to3");

        // at 3 heading up: 6 before 1
        issue(8'h42, T);
        wait_idle("scan");

        // floor 1 -> 2, extend dwell with a press at timer 5
        issue(8'h04, 35);
        wait_door(2'b01, "dw_open");
        wait_door(2'b00, "dw_hold");
        repeat (14) @(negedge clock);
        buttons = 8'h04;
        @(negedge clock);
        buttons = '0;
        @(negedge clock);
        chk("dwell_press_pending", int'(pending), 0);
        wait_idle("dwell");

        // door reversal while closing
        issue(8'h04, T);
        wait_door(2'b01, "rv_open");
        wait_door(2'b00, "rv_hold");
        wait_door(2'b10, "rv_close");
        sb.push_back('{2, T});
        buttons = 8'h04;
        @(negedge clock);
        buttons = '0;
        chk("reversal_door", int'(door), 1);
        wait_idle("reversal");

        // interlock during an upward move
        issue(8'h80, T);
        n = 0;
        while (engine != 2'b01 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("move_started", int'(n < 100), 1);
        @(posedge clock);
        #2 glitch = 1'b1;
        #1 chk("interlock_gate", int'(engine), 0);
        repeat (3) begin
            @(negedge clock);
            chk("interlock_hold", int'(engine), 0);
        end
        @(posedge clock);
        #2 glitch = 1'b0;
        #1 chk("interlock_resume", int'(engine), 1);
        wait_idle("interlock");

        for (int r = 0; r < 12; r++) begin
            mask = BW'($urandom_range(1, (1 << BW) - 1));
            issue(mask, T);
            wait_idle("random");
        end

        // reset in the middle of a move
        @(negedge clock);
        buttons = (m_floor < 4) ? 8'h80 : 8'h01;
        @(negedge clock);
        buttons = '0;
        n = 0;
        while (engine == 2'b00 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("move2_started", int'(n < 100), 1);
        @(posedge clock);
        #2 an_reset = 1'b1;
        pfloor = 0;
        #1;
        chk("mid_rst_engine", int'(engine), 0);
        chk("mid_rst_door", int'(door), 2);
        chk("mid_rst_floor", int'(floor), 0);
        chk("mid_rst_pending", int'(pending), 0);
        chk("mid_rst_busy", int'(busy), 1);
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
